// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage with IF/ID pipeline register.
//
// Drives the instruction ROM address combinationally from the PC and captures the
// returned word, together with its PC and PC+4, into the IF/ID register on the next
// rising edge. A small BOOT/RUN/HALT controller sequences start-up and stops fetch
// once a HALT_WORD has been accepted into IF/ID.
//
// Parameters:
//   RESET_PC   PC value loaded on reset.
//   HALT_WORD  Instruction encoding that halts fetch.
//
// Ports:
//   clk              single clock, all state updates on its rising edge
//   reset            synchronous, active-high reset
//   stall_i          hold PC and IF/ID
//   flush_i          squash IF/ID to NOP
//   branch_taken_i   redirect PC to branch_target_i (word aligned)
//   branch_target_i  redirect address
//   imem_addr_o      byte address to instruction ROM (equals PC)
//   imem_rd_i        instruction word from ROM, combinational from imem_addr_o
//   instr_id_o, pc_id_o, pc_plus4_id_o, valid_id_o   IF/ID register
//   halted_o         high while in HALT
//   fetch_count_o    valid IF/ID loads (performance counter)
//   stall_count_o    stalled RUN cycles (performance counter)
//
// Configuration:
//   FETCH_PERF_CNT_EN  when defined, builds the two performance counters; otherwise
//                      both counter outputs are tied to zero.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rd_i,
  output logic [31:0] instr_id_o,
  output logic [31:0] pc_id_o,
  output logic [31:0] pc_plus4_id_o,
  output logic        valid_id_o,
  output logic        halted_o,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
);

  localparam logic [31:0] Nop = 32'h0000_0000;

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic        fetch_inc;
  logic        stall_inc;

  // Wraps naturally at 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_id_d   = pc_id_q;
    pc4_id_d  = pc4_id_q;
    valid_d   = valid_q;
    fetch_inc = 1'b0;
    stall_inc = 1'b0;

    unique case (state_q)
      StBoot: begin
        pc_d     = RESET_PC;
        instr_d  = Nop;
        pc_id_d  = '0;
        pc4_id_d = '0;
        valid_d  = 1'b0;
        state_d  = StRun;
      end

      StRun: begin
        if (branch_taken_i) begin
          // Branch wins over stall: the in-flight fetch is discarded.
          pc_d     = {branch_target_i[31:2], 2'b00};
          instr_d  = Nop;
          pc_id_d  = '0;
          pc4_id_d = '0;
          valid_d  = 1'b0;
        end else if (flush_i) begin
          instr_d  = Nop;
          pc_id_d  = '0;
          pc4_id_d = '0;
          valid_d  = 1'b0;
          if (!stall_i) begin
            pc_d = pc_plus4;
          end
        end else if (stall_i) begin
          stall_inc = 1'b1;
        end else begin
          instr_d   = imem_rd_i;
          pc_id_d   = pc_q;
          pc4_id_d  = pc_plus4;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
          fetch_inc = 1'b1;
          // Halt only on a word actually accepted into IF/ID; the halt word stays
          // visible as a valid entry for the first HALT cycle.
          if (imem_rd_i == HALT_WORD) begin
            state_d = StHalt;
          end
        end
      end

      StHalt: begin
        instr_d  = Nop;
        pc_id_d  = '0;
        pc4_id_d = '0;
        valid_d  = 1'b0;
      end

      default: begin
        state_d  = StBoot;
        pc_d     = RESET_PC;
        instr_d  = Nop;
        pc_id_d  = '0;
        pc4_id_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      instr_q  <= Nop;
      pc_id_q  <= '0;
      pc4_id_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_id_q  <= pc_id_d;
      pc4_id_q <= pc4_id_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign instr_id_o    = instr_q;
  assign pc_id_o       = pc_id_q;
  assign pc_plus4_id_o = pc4_id_q;
  assign valid_id_o    = valid_q;
  assign halted_o      = (state_q == StHalt);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_inc};
    stall_cnt_d = stall_cnt_q + {31'd0, stall_inc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;
`else
  assign fetch_count_o = '0;
  assign stall_count_o = '0;

  logic unused_cnt_inc;
  assign unused_cnt_inc = fetch_inc ^ stall_inc;
`endif

  // Low target bits are dropped by word alignment.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target_i[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Directed table of per-cycle vectors, a few hand-written corner sequences, then
// randomized stimulus compared against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rd_i;
  logic [31:0] instr_id_o;
  logic [31:0] pc_id_o;
  logic [31:0] pc_plus4_id_o;
  logic        valid_id_o;
  logic        halted_o;
  logic [31:0] fetch_count_o;
  logic [31:0] stall_count_o;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(HaltWord)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .imem_addr_o    (imem_addr_o),
    .imem_rd_i      (imem_rd_i),
    .instr_id_o     (instr_id_o),
    .pc_id_o        (pc_id_o),
    .pc_plus4_id_o  (pc_plus4_id_o),
    .valid_id_o     (valid_id_o),
    .halted_o       (halted_o),
    .fetch_count_o  (fetch_count_o),
    .stall_count_o  (stall_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM: 64 words, index wraps on address bits [7:2].
  logic [31:0] rom [64];
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
    rom[6] = HaltWord;
  end
  assign imem_rd_i = rom[imem_addr_o[7:2]];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_booting;
  bit          m_halted;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcid;
  logic [31:0] m_pc4;
  bit          m_valid;
  logic [31:0] m_fetches;
  logic [31:0] m_stalls;

  task automatic model_bubble();
    m_instr = 32'h0; m_pcid = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit fl, input bit br,
                            input logic [31:0] tgt, input logic [31:0] word);
    if (r) begin
      m_pc = 32'h0; m_booting = 1'b1; m_halted = 1'b0;
      m_fetches = 32'h0; m_stalls = 32'h0;
      model_bubble();
    end else if (m_booting) begin
      m_booting = 1'b0;
      model_bubble();
    end else if (m_halted) begin
      model_bubble();
    end else if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      model_bubble();
    end else if (fl) begin
      model_bubble();
      if (!st) m_pc = m_pc + 32'd4;
    end else if (st) begin
      m_stalls = m_stalls + 32'd1;
    end else begin
      m_instr = word; m_pcid = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_fetches = m_fetches + 32'd1;
      m_pc = m_pc + 32'd4;
      if (word == HaltWord) m_halted = 1'b1;
    end
  endtask

  task automatic check_model(input int cyc);
    string s;
    s = $sformatf("rand%0d", cyc);
    check({s, ".addr"},   imem_addr_o,       m_pc);
    check({s, ".instr"},  instr_id_o,        m_instr);
    check({s, ".pc_id"},  pc_id_o,           m_pcid);
    check({s, ".pc4"},    pc_plus4_id_o,     m_pc4);
    check({s, ".valid"},  {31'd0, valid_id_o}, {31'd0, m_valid});
    check({s, ".halted"}, {31'd0, halted_o},   {31'd0, m_halted});
    check({s, ".fcnt"},   fetch_count_o,     PerfEn ? m_fetches : 32'h0);
    check({s, ".scnt"},   stall_count_o,     PerfEn ? m_stalls : 32'h0);
  endtask

  // Apply inputs for one cycle, advance the model at the edge, sample #1 later.
  task automatic step(input bit r, input bit st, input bit fl, input bit br,
                      input logic [31:0] tgt);
    reset = r; stall_i = st; flush_i = fl; branch_taken_i = br; branch_target_i = tgt;
    @(posedge clk);
    model_step(r, st, fl, br, tgt, rom[m_pc[7:2]]);
    #1;
  endtask

  // Constant-expectation check of the IF/ID register, address and halt flag.
  task automatic expect_if(input string n, input logic [31:0] instr, input logic [31:0] pcid,
                           input logic [31:0] addr, input bit v, input bit h);
    logic [31:0] p4;
    p4 = v ? (pcid + 32'd4) : 32'h0;
    check({n, ".instr"},  instr_id_o,          instr);
    check({n, ".pc_id"},  pc_id_o,             pcid);
    check({n, ".pc4"},    pc_plus4_id_o,       p4);
    check({n, ".valid"},  {31'd0, valid_id_o}, {31'd0, v});
    check({n, ".addr"},   imem_addr_o,         addr);
    check({n, ".halted"}, {31'd0, halted_o},   {31'd0, h});
  endtask

  typedef struct {
    bit          rst, st, fl, br;
    logic [31:0] tgt;
    logic [31:0] instr, pcid, addr;
    bit          v, h;
  } vec_t;

  function automatic vec_t mk(bit rst, bit st, bit fl, bit br, logic [31:0] tgt,
                              logic [31:0] instr, logic [31:0] pcid, logic [31:0] addr,
                              bit v, bit h);
    vec_t x;
    x.rst = rst; x.st = st; x.fl = fl; x.br = br; x.tgt = tgt;
    x.instr = instr; x.pcid = pcid; x.addr = addr; x.v = v; x.h = h;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0; branch_taken_i = 1'b0;
    branch_target_i = 32'h0;

    //              rst st fl br tgt           instr         pc_id   addr  v  h
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  32'h0,         32'h00, 32'h00, 0, 0)); // 0 reset
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h0,         32'h00, 32'h00, 0, 0)); // 1 boot
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0000, 32'h00, 32'h04, 1, 0)); // 2
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0001, 32'h04, 32'h08, 1, 0)); // 3
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0002, 32'h08, 32'h0C, 1, 0)); // 4
    tbl.push_back(mk(0, 1, 0, 1, 32'h16, 32'h0,         32'h00, 32'h14, 0, 0)); // 5 br+stall
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0005, 32'h14, 32'h18, 1, 0)); // 6
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  HaltWord,      32'h18, 32'h1C, 1, 1)); // 7 halt
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,  32'h0,         32'h00, 32'h1C, 0, 1)); // 8 br ignored
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h0,         32'h00, 32'h1C, 0, 1)); // 9
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  32'h0,         32'h00, 32'h00, 0, 0)); // 10 reset
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h0,         32'h00, 32'h00, 0, 0)); // 11 boot
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0000, 32'h00, 32'h04, 1, 0)); // 12
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0001, 32'h04, 32'h08, 1, 0)); // 13
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h1000_0001, 32'h04, 32'h08, 1, 0)); // 14 stall
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h1000_0001, 32'h04, 32'h08, 1, 0)); // 15 stall
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h1000_0001, 32'h04, 32'h08, 1, 0)); // 16 stall
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0002, 32'h08, 32'h0C, 1, 0)); // 17
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h0,         32'h00, 32'h0C, 0, 0)); // 18 fl+st
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,         32'h00, 32'h10, 0, 0)); // 19 flush
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0004, 32'h10, 32'h14, 1, 0)); // 20
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0005, 32'h14, 32'h18, 1, 0)); // 21
    tbl.push_back(mk(0, 0, 0, 1, 32'h8,  32'h0,         32'h00, 32'h08, 0, 0)); // 22 br @0x18
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1000_0002, 32'h08, 32'h0C, 1, 0)); // 23

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].fl, tbl[i].br, tbl[i].tgt);
      expect_if($sformatf("vec%0d", i), tbl[i].instr, tbl[i].pcid, tbl[i].addr,
                tbl[i].v, tbl[i].h);
      if (i == 9) check("vec9.fcnt", fetch_count_o, PerfEn ? 32'd5 : 32'd0);
      if (i == 16) begin
        check("vec16.scnt", stall_count_o, PerfEn ? 32'd3 : 32'd0);
        check("vec16.fcnt", fetch_count_o, PerfEn ? 32'd2 : 32'd0);
      end
    end

    // PC+4 wraps past 0xFFFF_FFFC.
    step(0, 0, 0, 1, 32'hFFFF_FFFF);
    expect_if("wrap.br", 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 0, 32'h0);
    expect_if("wrap.fetch", 32'h1000_003F, 32'hFFFF_FFFC, 32'h0, 1, 0);
    step(0, 0, 0, 0, 32'h0);
    expect_if("wrap.next", 32'h1000_0000, 32'h0, 32'h4, 1, 0);

    // Flush squashing the halt word must not halt.
    step(0, 0, 0, 1, 32'h18);
    expect_if("sqh.br", 32'h0, 32'h0, 32'h18, 0, 0);
    step(0, 0, 1, 0, 32'h0);
    expect_if("sqh.flush", 32'h0, 32'h0, 32'h1C, 0, 0);
    step(0, 0, 0, 0, 32'h0);
    expect_if("sqh.next", 32'h1000_0007, 32'h1C, 32'h20, 1, 0);

    // Reset overrides a simultaneous branch and stall; BOOT ignores a branch.
    step(1, 1, 0, 1, 32'h40);
    expect_if("rstov", 32'h0, 32'h0, 32'h0, 0, 0);
    check("rstov.fcnt", fetch_count_o, 32'h0);
    check("rstov.scnt", stall_count_o, 32'h0);
    step(0, 0, 0, 1, 32'h40);
    expect_if("boot.br", 32'h0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 32'h0);
    expect_if("boot.after", 32'h1000_0000, 32'h0, 32'h4, 1, 0);

    // Randomized stimulus against the reference model.
    for (int c = 0; c < 3000; c++) begin
      bit r, st, fl, br;
      logic [31:0] tgt;
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 25);
      fl = ($urandom_range(0, 99) < 10);
      br = ($urandom_range(0, 99) < 10);
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      step(r, st, fl, br, tgt);
      check_model(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
